// File: rtl/turbo_encoder_block.sv
// turbo_encoder_block
// Serial-in, rate-1/3 parallel-concatenated (turbo) encoder with a single
// K-bit block buffer. A block of K information bits is loaded serially, then
// emitted as K triplets {systematic, parity1, parity2}. Parity1 comes from
// RSC1 fed in natural order; parity2 comes from RSC2 fed through one of four
// interleavers chosen by select_interleaver at the first bit of the block.
//
// Optional feature macro: TURBO_TAIL_EN
//   When defined, ENCODE is followed by a TAIL state that emits three
//   termination triplets which drive both RSC states back to 000.
//   When undefined, the block ends on ENCODE triplet K-1.
module turbo_encoder_block #(
    parameter int K      = 8,
    parameter int STRIDE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] select_interleaver,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_data,
    output logic       out_last
);

    // Index width and derived constants (indices run 0..K-1)
    localparam int            IW       = $clog2(K);
    localparam int            IW1      = IW + 1;
    localparam logic [IW-1:0] ZERO_IDX = IW'(0);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
    localparam logic [IW:0]   K_EXT    = IW1'(K);
    localparam logic [IW:0]   TWO_EXT  = IW1'(2);
    localparam logic [IW:0]   STEP_EXT = IW1'(STRIDE % K);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ENCODE = 2'd2;
`ifdef TURBO_TAIL_EN
    localparam logic [1:0] ST_TAIL   = 2'd3;
`endif

    // One RSC trellis step. State is {s1,s2,s3}; result is {parity, next}.
    // Feedback a = u^s2^s3, parity = a^s1^s3, next state = {a,s1,s2}.
    function automatic logic [3:0] rsc_step(input logic [2:0] st, input logic u);
        logic a;
        a = u ^ st[1] ^ st[0];
        return {a ^ st[2] ^ st[0], a, st[2], st[1]};
    endfunction

`ifdef TURBO_TAIL_EN
    // Termination input: cancels the feedback so a shifts in as 0.
    function automatic logic rsc_tail_in(input logic [2:0] st);
        return st[1] ^ st[0];
    endfunction
`endif

    // Interleaved index of triplet 0 for each mode.
    function automatic logic [IW-1:0] pi_first(input logic [1:0] mode);
        logic [IW-1:0] r;
        case (mode)
            2'd1:    r = LAST_IDX;
            default: r = ZERO_IDX;
        endcase
        return r;
    endfunction

    // Interleaved index of triplet i+1 from that of triplet i. Every mode is
    // an increment/decrement or a modular add, so no multiplier is needed.
    function automatic logic [IW-1:0] pi_next(input logic [1:0] mode, input logic [IW-1:0] p);
        logic [IW:0]   sum;
        logic [IW-1:0] r;
        sum = {1'b0, p};
        case (mode)
            2'd0: r = p + ONE_IDX;
            2'd1: r = p - ONE_IDX;
            2'd2: begin
                // evens ascending, then wrap to index 1 for the odds
                sum = {1'b0, p} + TWO_EXT;
                if (sum > {1'b0, LAST_IDX}) begin
                    r = ONE_IDX;
                end else begin
                    r = sum[IW-1:0];
                end
            end
            2'd3: begin
                sum = {1'b0, p} + STEP_EXT;
                if (sum >= K_EXT) begin
                    sum = sum - K_EXT;
                end else begin
                    sum = sum;
                end
                r = sum[IW-1:0];
            end
            default: r = p;
        endcase
        return r;
    endfunction

    // Registered state
    logic [1:0]    state_r;
    logic [K-1:0]  buf_r;
    logic [IW-1:0] load_cnt_r;
    logic [1:0]    mode_r;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] pi_r;
    logic [2:0]    rsc1_r;
    logic [2:0]    rsc2_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [2:0]    out_data_r;
    logic          out_last_r;
`ifdef TURBO_TAIL_EN
    logic [1:0]    tail_cnt_r;
    logic [1:0]    tail_cnt_s;
`endif

    // Next-state values
    logic [1:0]    state_s;
    logic [K-1:0]  buf_s;
    logic [K-1:0]  buf_full_s;
    logic [IW-1:0] load_cnt_s;
    logic [1:0]    mode_s;
    logic [IW-1:0] idx_s;
    logic [IW-1:0] pi_s;
    logic [2:0]    rsc1_s;
    logic [2:0]    rsc2_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic [2:0]    out_data_s;
    logic          out_last_s;

    // Helpers
    logic          accept_in_s;
    logic          accept_out_s;
    logic          go_idle_s;
    logic [IW-1:0] nidx_s;
    logic [IW-1:0] npi_s;
    logic [IW-1:0] pi0_s;
    logic          u1_s;
    logic          u2_s;
    logic [3:0]    step1_s;
    logic [3:0]    step2_s;

    // FSM, load path and triplet generation
    always_comb begin
        state_s     = state_r;
        buf_s       = buf_r;
        load_cnt_s  = load_cnt_r;
        mode_s      = mode_r;
        idx_s       = idx_r;
        pi_s        = pi_r;
        rsc1_s      = rsc1_r;
        rsc2_s      = rsc2_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_last_s  = out_last_r;
`ifdef TURBO_TAIL_EN
        tail_cnt_s  = tail_cnt_r;
`endif
        go_idle_s    = 1'b0;
        accept_in_s  = in_valid & in_ready_r;
        accept_out_s = out_valid_r & out_ready;
        // Buffer as it will look once the bit on in_bit is written; triplet 0
        // is built from this so the final bit needs no extra cycle.
        buf_full_s             = buf_r;
        buf_full_s[load_cnt_r] = in_bit;
        nidx_s  = idx_r + ONE_IDX;
        npi_s   = pi_next(mode_r, pi_r);
        pi0_s   = pi_first(mode_r);
        u1_s    = 1'b0;
        u2_s    = 1'b0;
        step1_s = 4'd0;
        step2_s = 4'd0;

        case (state_r)
            ST_IDLE, ST_LOAD: begin
                in_ready_s = 1'b1;
                if (accept_in_s) begin
                    buf_s = buf_full_s;
                    if (state_r == ST_IDLE) begin
                        mode_s = select_interleaver;
                    end else begin
                        mode_s = mode_r;
                    end
                    if (load_cnt_r == LAST_IDX) begin
                        // Block complete: present triplet 0 from zero state
                        u1_s        = buf_full_s[0];
                        u2_s        = buf_full_s[pi0_s];
                        step1_s     = rsc_step(3'b000, u1_s);
                        step2_s     = rsc_step(3'b000, u2_s);
                        out_data_s  = {u1_s, step1_s[3], step2_s[3]};
                        rsc1_s      = step1_s[2:0];
                        rsc2_s      = step2_s[2:0];
                        idx_s       = ZERO_IDX;
                        pi_s        = pi0_s;
                        load_cnt_s  = ZERO_IDX;
                        out_valid_s = 1'b1;
                        out_last_s  = 1'b0;
                        in_ready_s  = 1'b0;
                        state_s     = ST_ENCODE;
                    end else begin
                        load_cnt_s = load_cnt_r + ONE_IDX;
                        state_s    = ST_LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            ST_ENCODE: begin
                if (accept_out_s) begin
                    if (idx_r == LAST_IDX) begin
`ifdef TURBO_TAIL_EN
                        // First termination triplet
                        u1_s       = rsc_tail_in(rsc1_r);
                        u2_s       = rsc_tail_in(rsc2_r);
                        step1_s    = rsc_step(rsc1_r, u1_s);
                        step2_s    = rsc_step(rsc2_r, u2_s);
                        out_data_s = {u1_s, step1_s[3], step2_s[3]};
                        rsc1_s     = step1_s[2:0];
                        rsc2_s     = step2_s[2:0];
                        out_last_s = 1'b0;
                        tail_cnt_s = 2'd0;
                        state_s    = ST_TAIL;
`else
                        go_idle_s = 1'b1;
`endif
                    end else begin
                        u1_s       = buf_r[nidx_s];
                        u2_s       = buf_r[npi_s];
                        step1_s    = rsc_step(rsc1_r, u1_s);
                        step2_s    = rsc_step(rsc2_r, u2_s);
                        out_data_s = {u1_s, step1_s[3], step2_s[3]};
                        rsc1_s     = step1_s[2:0];
                        rsc2_s     = step2_s[2:0];
                        idx_s      = nidx_s;
                        pi_s       = npi_s;
`ifdef TURBO_TAIL_EN
                        out_last_s = 1'b0;
`else
                        out_last_s = (nidx_s == LAST_IDX);
`endif
                    end
                end else begin
                    // stalled: triplet and RSC states hold
                    state_s = state_r;
                end
            end

`ifdef TURBO_TAIL_EN
            ST_TAIL: begin
                if (accept_out_s) begin
                    if (tail_cnt_r == 2'd2) begin
                        go_idle_s = 1'b1;
                    end else begin
                        u1_s       = rsc_tail_in(rsc1_r);
                        u2_s       = rsc_tail_in(rsc2_r);
                        step1_s    = rsc_step(rsc1_r, u1_s);
                        step2_s    = rsc_step(rsc2_r, u2_s);
                        out_data_s = {u1_s, step1_s[3], step2_s[3]};
                        rsc1_s     = step1_s[2:0];
                        rsc2_s     = step2_s[2:0];
                        out_last_s = (tail_cnt_r == 2'd1);
                        tail_cnt_s = tail_cnt_r + 2'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
`endif

            default: begin
                go_idle_s = 1'b1;
            end
        endcase

        // Common return to IDLE: block done (or unreachable state recovered)
        if (go_idle_s) begin
            state_s     = ST_IDLE;
            buf_s       = {K{1'b0}};
            load_cnt_s  = ZERO_IDX;
            idx_s       = ZERO_IDX;
            pi_s        = ZERO_IDX;
            rsc1_s      = 3'b000;
            rsc2_s      = 3'b000;
            in_ready_s  = 1'b1;
            out_valid_s = 1'b0;
            out_data_s  = 3'b000;
            out_last_s  = 1'b0;
`ifdef TURBO_TAIL_EN
            tail_cnt_s  = 2'd0;
`endif
        end else begin
            state_s = state_s;
        end
    end

    // State and output registers; reset clears everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            buf_r       <= {K{1'b0}};
            load_cnt_r  <= ZERO_IDX;
            mode_r      <= 2'd0;
            idx_r       <= ZERO_IDX;
            pi_r        <= ZERO_IDX;
            rsc1_r      <= 3'b000;
            rsc2_r      <= 3'b000;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 3'b000;
            out_last_r  <= 1'b0;
`ifdef TURBO_TAIL_EN
            tail_cnt_r  <= 2'd0;
`endif
        end else begin
            state_r     <= state_s;
            buf_r       <= buf_s;
            load_cnt_r  <= load_cnt_s;
            mode_r      <= mode_s;
            idx_r       <= idx_s;
            pi_r        <= pi_s;
            rsc1_r      <= rsc1_s;
            rsc2_r      <= rsc2_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_last_r  <= out_last_s;
`ifdef TURBO_TAIL_EN
            tail_cnt_r  <= tail_cnt_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_turbo_encoder_block.sv
// Directed, table-driven bench for turbo_encoder_block (K=8, STRIDE=3).
// Expected parity sequences are hand-derived from the RSC impulse response
// 1,1,1,1,0,0,1,0 (linear code, zero start state). Bit i of each vector is
// index i / triplet i.
module tb_turbo_encoder_block;

    localparam int K = 8;
`ifdef TURBO_TAIL_EN
    localparam int NT = K + 3;
`else
    localparam int NT = K;
`endif
    localparam int BUDGET = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] select_interleaver;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       out_last;

    turbo_encoder_block #(.K(K), .STRIDE(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .select_interleaver (select_interleaver),
        .in_valid           (in_valid),
        .in_bit             (in_bit),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] intl;  // d[pi(i)], the sequence RSC2 sees
        logic [7:0] sys;
        logic [7:0] p1;
        logic [7:0] p2;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] rec_data [0:15];
    logic       rec_last [0:15];
    int         rec_cnt;
    logic       stall_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one block; select_interleaver is scrambled after bit 0 to show it
    // is only sampled at block start.
    task automatic send_block(input logic [1:0] mode, input logic [7:0] data);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready before block", 32'(in_ready), 32'd1);
        for (int i = 0; i < K; i++) begin
            in_valid           = 1'b1;
            in_bit             = data[i];
            select_interleaver = (i == 0) ? mode : ~mode;
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check("out_valid one cycle after bit K-1", 32'(out_valid), 32'd1);
        check("in_ready low while encoding", 32'(in_ready), 32'd0);
    endtask

    // Drain triplets. stall_at: triplet held with out_ready=0 for 5 cycles.
    // abort_at: stop before accepting that triplet. in_valid is kept high
    // during encoding to show it is ignored.
    task automatic collect(input int n, input int stall_at, input int abort_at);
        int         cyc;
        int         stall_cnt;
        logic [2:0] held;
        cyc       = 0;
        stall_cnt = 0;
        held      = 3'b000;
        rec_cnt   = 0;
        stall_ok  = 1'b1;
        while (rec_cnt < n && rec_cnt != abort_at && cyc < BUDGET) begin
            in_valid = (rec_cnt < n - 1);
            in_bit   = 1'b1;
            if (rec_cnt == stall_at && stall_cnt < 5) begin
                out_ready = 1'b0;
                if (stall_cnt == 0) begin
                    held = out_data;
                end else if (out_data !== held || out_valid !== 1'b1) begin
                    stall_ok = 1'b0;
                end
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                rec_data[rec_cnt] = out_data;
                rec_last[rec_cnt] = out_last;
                rec_cnt++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        check("collect within cycle budget", 32'(rec_cnt == n || rec_cnt == abort_at), 32'd1);
    endtask

`ifdef TURBO_TAIL_EN
    function automatic logic [2:0] rsc_run(input logic [7:0] u);
        logic [2:0] st;
        logic       a;
        st = 3'b000;
        for (int i = 0; i < 8; i++) begin
            a  = u[i] ^ st[1] ^ st[0];
            st = {a, st[2], st[1]};
        end
        return st;
    endfunction
`endif

    // Compare a drained block against its table record.
    task automatic verify(input int vi);
        logic [7:0]  sys_g;
        logic [7:0]  p1_g;
        logic [7:0]  p2_g;
        logic [15:0] last_g;
        sys_g  = 8'd0;
        p1_g   = 8'd0;
        p2_g   = 8'd0;
        last_g = 16'd0;
        for (int i = 0; i < K; i++) begin
            sys_g[i] = rec_data[i][2];
            p1_g[i]  = rec_data[i][1];
            p2_g[i]  = rec_data[i][0];
        end
        for (int i = 0; i < NT; i++) begin
            last_g[i] = rec_last[i];
        end
        check($sformatf("vec%0d sys", vi), 32'(sys_g), 32'(vecs[vi].sys));
        check($sformatf("vec%0d p1", vi), 32'(p1_g), 32'(vecs[vi].p1));
        check($sformatf("vec%0d p2", vi), 32'(p2_g), 32'(vecs[vi].p2));
        check($sformatf("vec%0d out_last position", vi), 32'(last_g), 32'd1 << (NT - 1));
`ifdef TURBO_TAIL_EN
        begin
            logic [2:0] s1;
            logic [2:0] s2;
            logic [2:0] exp_t;
            s1 = rsc_run(vecs[vi].data);
            s2 = rsc_run(vecs[vi].intl);
            for (int t = 0; t < 3; t++) begin
                exp_t = {s1[1] ^ s1[0], s1[2] ^ s1[0], s2[2] ^ s2[0]};
                check($sformatf("vec%0d tail%0d", vi, t), 32'(rec_data[K + t]), 32'(exp_t));
                s1 = {1'b0, s1[2], s1[1]};
                s2 = {1'b0, s2[2], s2[1]};
            end
        end
`endif
        check($sformatf("vec%0d out_valid low after block", vi), 32'(out_valid), 32'd0);
        check($sformatf("vec%0d in_ready back after block", vi), 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_data"}, 32'(out_data), 32'd0);
        check({tag, " out_last"}, 32'(out_last), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        //            mode   data          intl          sys           p1            p2
        vecs[0] = '{2'd0, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b0000_0000};
        vecs[1] = '{2'd0, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001, 8'b0100_1111, 8'b0100_1111};
        vecs[2] = '{2'd1, 8'b0000_0001, 8'b1000_0000, 8'b0000_0001, 8'b0100_1111, 8'b1000_0000};
        vecs[3] = '{2'd3, 8'b0000_1000, 8'b0000_0010, 8'b0000_1000, 8'b0111_1000, 8'b1001_1110};
        vecs[4] = '{2'd2, 8'b0000_0010, 8'b0001_0000, 8'b0000_0010, 8'b1001_1110, 8'b1111_0000};
        vecs[5] = '{2'd1, 8'b0000_0011, 8'b1100_0000, 8'b0000_0011, 8'b1101_0001, 8'b0100_0000};
        vecs[6] = '{2'd3, 8'b1000_0000, 8'b0010_0000, 8'b1000_0000, 8'b1000_0000, 8'b1110_0000};
        vecs[7] = '{2'd2, 8'b1111_1111, 8'b1111_1111, 8'b1111_1111, 8'b1100_0101, 8'b1100_0101};
        vecs[8] = '{2'd1, 8'b1000_0000, 8'b0000_0001, 8'b1000_0000, 8'b1000_0000, 8'b0100_1111};

        reset              = 1'b1;
        select_interleaver = 2'd0;
        in_valid           = 1'b0;
        in_bit             = 1'b0;
        out_ready          = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("during reset");
        reset = 1'b0;
        tick();
        check("in_ready first edge after reset", 32'(in_ready), 32'd1);

        // Table: every vector with out_ready held high
        for (int v = 0; v < NV; v++) begin
            send_block(vecs[v].mode, vecs[v].data);
            collect(NT, -1, -1);
            verify(v);
        end

        // Backpressure: hold triplet 4 for 5 cycles, sequence must match table
        send_block(vecs[5].mode, vecs[5].data);
        collect(NT, 4, -1);
        check("stall holds out_data", 32'(stall_ok), 32'd1);
        verify(5);

        // Reset in the middle of a block while triplet 3 is presented
        send_block(vecs[7].mode, vecs[7].data);
        collect(NT, -1, 3);
        check("triplets accepted before mid-block reset", 32'(rec_cnt), 32'd3);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid-block reset");
        tick();
        reset = 1'b0;
        tick();
        check("in_ready after mid-block reset", 32'(in_ready), 32'd1);
        send_block(vecs[1].mode, vecs[1].data);
        collect(NT, -1, -1);
        verify(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
